ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage placed directly downstream of the ID/EX pipeline register.
- Consumes the decoded E-stage controls and operands, applies MEM/WB forwarding, and computes the ALU result and destination register.
- Owns the HI/LO registers: single-cycle multiply and a 32-iteration restoring divider, which stalls the front end while busy.
- Registers its results into the MEM stage, so the EX/MEM register is part of this block.

Parameters:
- DIV_ITERS, 32, number of divider iterations; fixed at 32 for 32-bit operands.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- rsE, rtE, rdE  input  5 each  register specifiers.
- imm16E  input  16  immediate field.
- saE  input  5  shift amount.
- extOpE  input  2  immediate extension: 0 = zero-extend, 1 = sign-extend, 2 = {imm, 16'h0}.
- aluOpE  input  4  operation select, encoded below.
- aluSrc2_muxE  input  1  operand B select: 0 = forwarded rt value, 1 = extended immediate.
- regDst_muxE  input  2  destination select: 0 = rt, 1 = rd, 2 = register 31.
- Regfile_weE, DataMem_weE  input  1 each  write enables.
- regSrc_muxE  input  2  passed through to MEM/WB.
- readData1E, readData2E  input  32 each  register-file read data.
- resultW  input  32  writeback data.
- writeRegW  input  5  writeback destination.
- Regfile_weW  input  1  writeback enable.
- stallE  output  1  hold PC, IF/ID and ID/EX.
- aluOutM, writeDataM  output  32 each  registered ALU result and store data.
- writeRegM  output  5  registered destination.
- Regfile_weM, DataMem_weM  output  1 each  registered write enables.
- regSrc_muxM  output  2  registered pass-through.
- hi, lo  output  32 each  HI/LO register contents.

Behaviour:
- Reset (rst low, asynchronous): all M outputs, hi and lo are 0; divider FSM goes to IDLE; stallE is 0.
- Forwarding for operand A (source rsE) and the rt value (source rtE), in priority order:
  - aluOutM when Regfile_weM=1, writeRegM=src and src≠0;
  - otherwise resultW when Regfile_weW=1, writeRegW=src and src≠0;
  - otherwise the readData port.
- Operand B is the forwarded rt value, or the extended immediate when aluSrc2_muxE=1.
- aluOpE encoding (all arithmetic is modulo 2^32, with no overflow trap):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR;
  - 6 SLT (signed) and 7 SLTU (unsigned), result 0 or 1;
  - 8 SLL, 9 SRL, A SRA, each shifting B by saE;
  - B PASSB.
- MULT/MULTU/DIV/DIVU (aluOpE C–F):
  - aluOut = 0 and the GPR write is suppressed: Regfile_weM and DataMem_weM are forced to 0 on the registering edge.
  - C MULT / D MULTU: signed / unsigned 32×32 → 64-bit product; at the same edge, {hi,lo} ← product.
- writeRegE = rtE, rdE or 5'd31 according to regDst_muxE; regDst_muxE=3 is treated as rt.
- EX/MEM register: one-cycle latency; loads every posedge while stallE=0.
- Divider FSM, states IDLE → RUN → DONE:
  - IDLE, with a DIV (E) or DIVU (F) in E:
    - If divisor ≠ 0: latch the magnitudes of forwarded A and B, the sign bits (DIV only) and the opcode; clear the counter; go to RUN. stallE=1 combinationally in this cycle, because the forwarding sources drain during the stall and operands are taken only here.
    - If divisor = 0: no RUN; hi and lo are unchanged; the instruction leaves in 1 cycle with stallE=0.
  - RUN: one restoring shift-subtract step per cycle; stallE=1; the counter increments; after DIV_ITERS steps go to DONE.
  - DONE: stallE=0; write lo = quotient and hi = remainder; EX/MEM loads a bubble (both enables 0); return to IDLE.
  - Total: 33 stall cycles, 34 cycles occupancy in E.
  - Signed correction: quotient negated if signA^signB; remainder takes signA. INT_MIN/−1 gives lo=0x80000000, hi=0.
- While stallE=1, EX/MEM loads a bubble every cycle (enables 0, other fields don't-care); upstream holds E inputs stable.
- Async reset during RUN aborts the divide: hi=lo=0, FSM in IDLE.

Test Plan:
- ADD r3=r1+r2 immediately after a producer of r1 in MEM (aluOutM=5) and r2 in WB (resultW=7), with readData ports = 0 → aluOutM=12 next cycle.
- Same register r1 in both MEM (value 1) and WB (value 2), and rsE=0 with readData1E=9 → MEM wins giving 1; rsE=0 ignores forwarding and yields 9.
- SLT with 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0. SRA of 0x80000000 by 4 → 0xF8000000. LUI (extOp=2, PASSB, imm 0x1234) → 0x12340000.
- MULT 0xFFFFFFFF × 2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same → hi=1, lo=0xFFFFFFFE; Regfile_weM=0.
- DIVU 100/7 → stallE high exactly 33 cycles, then lo=14, hi=2. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV by 0 → no stall, hi/lo unchanged.
- Assert rst low 10 cycles into a DIV → stallE=0, hi=lo=0 immediately. After release, DIVU 9/3 completes normally with lo=3.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, HI/LO multiply/divide unit and the EX/MEM register.
// A DIV/DIVU holds the front end for 33 cycles while the restoring divider iterates.
module ex_stage #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  rdE,
    input  logic [15:0] imm16E,
    input  logic [4:0]  saE,
    input  logic [1:0]  extOpE,
    input  logic [3:0]  aluOpE,
    input  logic        aluSrc2_muxE,
    input  logic [1:0]  regDst_muxE,
    input  logic        Regfile_weE,
    input  logic        DataMem_weE,
    input  logic [1:0]  regSrc_muxE,
    input  logic [31:0] readData1E,
    input  logic [31:0] readData2E,
    input  logic [31:0] resultW,
    input  logic [4:0]  writeRegW,
    input  logic        Regfile_weW,
    output logic        stallE,
    output logic [31:0] aluOutM,
    output logic [31:0] writeDataM,
    output logic [4:0]  writeRegM,
    output logic        Regfile_weM,
    output logic        DataMem_weM,
    output logic [1:0]  regSrc_muxM,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(DIV_ITERS);
    localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;
    div_state_e state_q, state_d;

    logic [31:0] src_a, rt_val, ext_imm, op_b, alu_res;
    logic [4:0]  write_reg;
    logic        is_md, is_div, op_signed, div_start;

    always_comb begin
        if (Regfile_weM && writeRegM == rsE && rsE != 5'd0)      src_a = aluOutM;
        else if (Regfile_weW && writeRegW == rsE && rsE != 5'd0) src_a = resultW;
        else                                                     src_a = readData1E;
        if (Regfile_weM && writeRegM == rtE && rtE != 5'd0)      rt_val = aluOutM;
        else if (Regfile_weW && writeRegW == rtE && rtE != 5'd0) rt_val = resultW;
        else                                                     rt_val = readData2E;
    end

    always_comb begin
        case (extOpE)
            2'd1:    ext_imm = {{16{imm16E[15]}}, imm16E};
            2'd2:    ext_imm = {imm16E, 16'h0};
            default: ext_imm = {16'h0, imm16E};
        endcase
        op_b = aluSrc2_muxE ? ext_imm : rt_val;
        case (regDst_muxE)
            2'd1:    write_reg = rdE;
            2'd2:    write_reg = 5'd31;
            default: write_reg = rtE;
        endcase
    end

    always_comb begin
        case (aluOpE)
            4'h0:    alu_res = src_a + op_b;
            4'h1:    alu_res = src_a - op_b;
            4'h2:    alu_res = src_a & op_b;
            4'h3:    alu_res = src_a | op_b;
            4'h4:    alu_res = src_a ^ op_b;
            4'h5:    alu_res = ~(src_a | op_b);
            4'h6:    alu_res = {31'b0, $signed(src_a) < $signed(op_b)};
            4'h7:    alu_res = {31'b0, src_a < op_b};
            4'h8:    alu_res = op_b << saE;
            4'h9:    alu_res = op_b >> saE;
            4'hA:    alu_res = $signed(op_b) >>> saE;
            4'hB:    alu_res = op_b;
            default: alu_res = 32'h0;
        endcase
    end

    // Opcodes C-F: bit1 selects divide, bit0 clear means signed.
    assign is_md     = aluOpE[3] & aluOpE[2];
    assign is_div    = is_md & aluOpE[1];
    assign op_signed = ~aluOpE[0];
    assign div_start = (state_q == IDLE) && is_div && (op_b != 32'h0);

    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic sign_a_q, sign_a_d, sign_b_q, sign_b_d, sgn_q, sgn_d;
    logic [32:0] shifted, diff;
    logic [31:0] q_fix, r_fix;

    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvsr_q};
    assign q_fix   = (sgn_q && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
    assign r_fix   = (sgn_q && sign_a_q) ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (div_start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stallE = rst && (state_q == RUN || div_start);
    end

    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        sgn_d    = sgn_q;
        if (div_start) begin
            sign_a_d = op_signed & src_a[31];
            sign_b_d = op_signed & op_b[31];
            sgn_d    = op_signed;
            quo_d    = (op_signed && src_a[31]) ? -src_a : src_a;
            dvsr_d   = (op_signed && op_b[31]) ? -op_b : op_b;
            rem_d    = 32'h0;
            cnt_d    = '0;
        end else if (state_q == RUN) begin
            rem_d = diff[32] ? shifted[31:0] : diff[31:0];
            quo_d = {quo_q[30:0], ~diff[32]};
            cnt_d = cnt_q + CW'(1);
        end
    end

    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    // Sign-extending to 64 bits makes one truncated multiply serve both MULT and MULTU.
    assign mul_a = {{32{op_signed & src_a[31]}}, src_a};
    assign mul_b = {{32{op_signed & op_b[31]}}, op_b};
    assign prod  = mul_a * mul_b;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == DONE) begin
            hi_d = r_fix;
            lo_d = q_fix;
        end else if (state_q == IDLE && is_md && !is_div) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
        end
    end

    logic [31:0] alu_out_q, alu_out_d, wdata_q, wdata_d;
    logic [4:0]  wreg_q, wreg_d;
    logic        rf_we_q, rf_we_d, dm_we_q, dm_we_d;
    logic [1:0]  rsrc_q, rsrc_d;

    always_comb begin
        alu_out_d = alu_res;
        wdata_d   = rt_val;
        wreg_d    = write_reg;
        rsrc_d    = regSrc_muxE;
        rf_we_d   = Regfile_weE & ~is_md & ~stallE;
        dm_we_d   = DataMem_weE & ~is_md & ~stallE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            sgn_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            alu_out_q <= '0;
            wdata_q   <= '0;
            wreg_q    <= '0;
            rf_we_q   <= 1'b0;
            dm_we_q   <= 1'b0;
            rsrc_q    <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            cnt_q     <= cnt_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            sgn_q     <= sgn_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            alu_out_q <= alu_out_d;
            wdata_q   <= wdata_d;
            wreg_q    <= wreg_d;
            rf_we_q   <= rf_we_d;
            dm_we_q   <= dm_we_d;
            rsrc_q    <= rsrc_d;
        end
    end

    assign aluOutM     = alu_out_q;
    assign writeDataM  = wdata_q;
    assign writeRegM   = wreg_q;
    assign Regfile_weM = rf_we_q;
    assign DataMem_weM = dm_we_q;
    assign regSrc_muxM = rsrc_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, HI/LO multiply/divide, stall length and reset abort.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rsE, rtE, rdE, saE, writeRegW;
    logic [15:0] imm16E;
    logic [1:0]  extOpE, regDst_muxE, regSrc_muxE;
    logic [3:0]  aluOpE;
    logic        aluSrc2_muxE, Regfile_weE, DataMem_weE, Regfile_weW;
    logic [31:0] readData1E, readData2E, resultW;
    logic        stallE, Regfile_weM, DataMem_weM;
    logic [31:0] aluOutM, writeDataM, hi, lo;
    logic [4:0]  writeRegM;
    logic [1:0]  regSrc_muxM;

    ex_stage dut (
        .clk(clk), .rst(rst), .rsE(rsE), .rtE(rtE), .rdE(rdE), .imm16E(imm16E), .saE(saE),
        .extOpE(extOpE), .aluOpE(aluOpE), .aluSrc2_muxE(aluSrc2_muxE), .regDst_muxE(regDst_muxE),
        .Regfile_weE(Regfile_weE), .DataMem_weE(DataMem_weE), .regSrc_muxE(regSrc_muxE),
        .readData1E(readData1E), .readData2E(readData2E), .resultW(resultW),
        .writeRegW(writeRegW), .Regfile_weW(Regfile_weW), .stallE(stallE),
        .aluOutM(aluOutM), .writeDataM(writeDataM), .writeRegM(writeRegM),
        .Regfile_weM(Regfile_weM), .DataMem_weM(DataMem_weM), .regSrc_muxM(regSrc_muxM),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] alu, input logic [4:0] wr, input logic we);
        exp_t e;
        e.tag = tag; e.alu = alu; e.wr = wr; e.we = we;
        sb.push_back(e);
    endtask

    // One clock; any pending expectation is retired against the EX/MEM outputs.
    task automatic tick();
        exp_t e;
        @(posedge clk); #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_alu"}, aluOutM, e.alu);
            chk({e.tag, "_wr"}, {27'b0, writeRegM}, {27'b0, e.wr});
            chk({e.tag, "_we"}, {31'b0, Regfile_weM}, {31'b0, e.we});
        end
    endtask

    task automatic clr();
        rsE = 0; rtE = 0; rdE = 0; imm16E = 0; saE = 0; extOpE = 0; aluOpE = 0;
        aluSrc2_muxE = 0; regDst_muxE = 0; Regfile_weE = 0; DataMem_weE = 0; regSrc_muxE = 0;
        readData1E = 0; readData2E = 0; resultW = 0; writeRegW = 0; Regfile_weW = 0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        clr();
        aluOpE = op; readData1E = a; readData2E = b; Regfile_weE = 1; regDst_muxE = 1; rdE = 5'd9;
    endtask

    task automatic wait_stall();
        cnt = 0;
        while (stallE === 1'b1 && cnt < 60) begin
            cnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clr();
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu", aluOutM, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_stall", {31'b0, stallE}, 32'h0);
        rst = 1;
        @(posedge clk); #1;

        // MEM producer r1=5, then ADD with r2 coming from WB
        clr(); aluOpE = 4'hB; aluSrc2_muxE = 1; imm16E = 16'd5; rtE = 1; Regfile_weE = 1;
        push("prod5", 32'd5, 5'd1, 1'b1);
        tick();
        clr(); aluOpE = 4'h0; rsE = 1; rtE = 2; rdE = 3; regDst_muxE = 1; Regfile_weE = 1;
        resultW = 32'd7; writeRegW = 2; Regfile_weW = 1;
        push("fwd_add", 32'd12, 5'd3, 1'b1);
        tick();

        // r1 in both MEM (1) and WB (2): MEM must win
        clr(); aluOpE = 4'hB; aluSrc2_muxE = 1; imm16E = 16'd1; rtE = 1; Regfile_weE = 1;
        push("prod1", 32'd1, 5'd1, 1'b1);
        tick();
        clr(); aluOpE = 4'h0; rsE = 1; rdE = 4; regDst_muxE = 1; Regfile_weE = 1;
        resultW = 32'd2; writeRegW = 1; Regfile_weW = 1;
        push("fwd_pri", 32'd1, 5'd4, 1'b1);
        tick();
        clr(); aluOpE = 4'h0; rdE = 5; regDst_muxE = 1; Regfile_weE = 1; readData1E = 32'd9;
        resultW = 32'd5; writeRegW = 0; Regfile_weW = 1;
        push("fwd_r0", 32'd9, 5'd5, 1'b1);
        tick();

        drive_op(4'h6, 32'hFFFF_FFFF, 32'd1);
        push("slt", 32'd1, 5'd9, 1'b1);
        tick();
        drive_op(4'h7, 32'hFFFF_FFFF, 32'd1);
        push("sltu", 32'd0, 5'd9, 1'b1);
        tick();
        drive_op(4'hA, 32'h0, 32'h8000_0000); saE = 5'd4;
        push("sra", 32'hF800_0000, 5'd9, 1'b1);
        tick();
        clr(); aluOpE = 4'hB; extOpE = 2; aluSrc2_muxE = 1; imm16E = 16'h1234; rtE = 6; Regfile_weE = 1;
        push("lui", 32'h1234_0000, 5'd6, 1'b1);
        tick();

        drive_op(4'hC, 32'hFFFF_FFFF, 32'd2);
        push("mult", 32'd0, 5'd9, 1'b0);
        tick();
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);
        drive_op(4'hD, 32'hFFFF_FFFF, 32'd2);
        push("multu", 32'd0, 5'd9, 1'b0);
        tick();
        chk("multu_hi", hi, 32'd1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        drive_op(4'hF, 32'd100, 32'd7);
        push("divu", 32'd0, 5'd9, 1'b0);
        #1;
        wait_stall();
        chk("divu_stall", cnt, 32'd33);
        tick();
        clr();
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        drive_op(4'hE, 32'hFFFF_FFF9, 32'd2);
        push("div", 32'd0, 5'd9, 1'b0);
        #1;
        wait_stall();
        chk("div_stall", cnt, 32'd33);
        tick();
        clr();
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        drive_op(4'hE, 32'd50, 32'd0);
        push("div0", 32'd0, 5'd9, 1'b0);
        #1;
        chk("div0_stall", {31'b0, stallE}, 32'h0);
        tick();
        chk("div0_lo", lo, 32'hFFFF_FFFD);
        chk("div0_hi", hi, 32'hFFFF_FFFF);

        // Reset in the middle of a divide
        drive_op(4'hE, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("abort_stall", {31'b0, stallE}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        drive_op(4'hF, 32'd9, 32'd3);
        push("divu93", 32'd0, 5'd9, 1'b0);
        #2;
        rst = 1;
        #1;
        wait_stall();
        chk("divu93_stall", cnt, 32'd33);
        tick();
        clr();
        chk("divu93_lo", lo, 32'd3);
        chk("divu93_hi", hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
